lap_stopwatch: RTL and testbench



---
 rtl/lap_stopwatch_if.sv | 36 +++
 rtl/lap_stopwatch.sv | 182 ++++++++++++++++++
 tb/tb_lap_stopwatch.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lap_stopwatch_if.sv
// Handshake bundle between the watch FSM / display mux (master) and the
// lap stopwatch (slave). Widths follow the stopwatch parameters.
interface lap_stopwatch_if #(
  parameter int MAX_MIN   = 59,
  parameter int LAP_DEPTH = 8
);
  localparam int MIN_W = $clog2(MAX_MIN + 1);
  localparam int IDX_W = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam int CNT_W = $clog2(LAP_DEPTH + 1);

  logic             stopwatch_mode_en;
  logic             sec_tick;
  logic             set;
  logic             lap;
  logic             recall;
  logic [MIN_W-1:0] min_out;
  logic [5:0]       sec_out;
  logic             show_lap;
  logic [IDX_W-1:0] lap_idx;
  logic [CNT_W-1:0] lap_count;
  logic             lap_full;
  logic             running;
  logic             overflow;

  modport master (
    output stopwatch_mode_en, sec_tick, set, lap, recall,
    input  min_out, sec_out, show_lap, lap_idx, lap_count, lap_full,
           running, overflow
  );

  modport slave (
    input  stopwatch_mode_en, sec_tick, set, lap, recall,
    output min_out, sec_out, show_lap, lap_idx, lap_count, lap_full,
           running, overflow
  );
endinterface

// File: rtl/lap_stopwatch.sv
// mm:ss stopwatch with a LAP_DEPTH-entry lap buffer, timed lap freeze on
// capture and lap recall while stopped. All outputs are registered.
module lap_stopwatch #(
  parameter int MAX_MIN    = 59,
  parameter int LAP_DEPTH  = 8,
  parameter int HOLD_TICKS = 2
) (
  input logic            clk,
  input logic            rst,
  lap_stopwatch_if.slave bus
);
  localparam int MIN_W  = $clog2(MAX_MIN + 1);
  localparam int IDX_W  = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam int CNT_W  = $clog2(LAP_DEPTH + 1);
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  typedef struct packed {
    logic [MIN_W-1:0] min;
    logic [5:0]       sec;
  } mmss_t;

  state_t           state_q, state_d;
  mmss_t            live_q, live_d, live_inc, disp_q, disp_d;
  mmss_t            laps_q [LAP_DEPTH];
  logic [CNT_W-1:0] count_q, count_d, ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             show_q, show_d, ovf_q, ovf_d, full_q, run_q;
  logic             wrap, cap_en, do_clear;

  // Live count advanced by one second, with wrap detection at MAX_MIN:59.
  always_comb begin
    live_inc = live_q;
    wrap     = 1'b0;
    if (live_q.sec == 6'd59) begin
      live_inc.sec = '0;
      if (live_q.min == MIN_W'(MAX_MIN)) begin
        live_inc.min = '0;
        wrap         = 1'b1;
      end else begin
        live_inc.min = live_q.min + MIN_W'(1);
      end
    end else begin
      live_inc.sec = live_q.sec + 6'd1;
    end
  end

  // NOTE: every variable gets a default at the top of the block, so no path
  // can leave one unassigned and infer a latch; combinational logic uses '='.
  always_comb begin
    state_d  = state_q;
    live_d   = live_q;
    count_d  = count_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    show_d   = show_q;
    idx_d    = idx_q;
    ovf_d    = ovf_q;
    cap_en   = 1'b0;
    do_clear = 1'b0;

    if (!bus.stopwatch_mode_en) begin
      do_clear = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.set) begin
            state_d = RUN;
            show_d  = 1'b0;
            ptr_d   = '0;
            hold_d  = '0;
          end
        end
        RUN: begin
          // The tick counts even when set stops the watch this cycle.
          if (bus.sec_tick) begin
            live_d = live_inc;
            if (wrap) ovf_d = 1'b1;
          end
          if (bus.set) begin
            state_d = STOP;
          end else if (bus.lap && !full_q) begin
            cap_en  = 1'b1;
            count_d = count_q + CNT_W'(1);
            show_d  = 1'b1;
            idx_d   = count_q[IDX_W-1:0];
            hold_d  = HOLD_W'(HOLD_TICKS);
          end
          if (!cap_en && show_q && bus.sec_tick) begin
            if (hold_q <= HOLD_W'(1)) begin
              show_d = 1'b0;
              hold_d = '0;
            end else begin
              hold_d = hold_q - HOLD_W'(1);
            end
          end
        end
        STOP: begin
          if (bus.set) begin
            state_d = RUN;
            show_d  = 1'b0;
            ptr_d   = '0;
            hold_d  = '0;
          end else if (bus.lap) begin
            do_clear = 1'b1;
          end else if (bus.recall && count_q != '0) begin
            hold_d = '0;
            // ptr_q == count_q means every entry has been shown: back to live.
            if (ptr_q < count_q) begin
              show_d = 1'b1;
              idx_d  = ptr_q[IDX_W-1:0];
              ptr_d  = ptr_q + CNT_W'(1);
            end else begin
              show_d = 1'b0;
              ptr_d  = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (do_clear) begin
      state_d = IDLE;
      live_d  = '0;
      count_d = '0;
      ptr_d   = '0;
      hold_d  = '0;
      show_d  = 1'b0;
      idx_d   = '0;
      ovf_d   = 1'b0;
    end

    // A fresh capture shows the pre-increment count that is being written.
    if (cap_en)      disp_d = live_q;
    else if (show_d) disp_d = laps_q[idx_d];
    else             disp_d = live_d;
  end

  // NOTE: the lap buffer is reset along with the control state so a recall
  // can never expose stale contents; sequential state uses '<=' only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      live_q  <= '0;
      disp_q  <= '0;
      count_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      idx_q   <= '0;
      show_q  <= 1'b0;
      ovf_q   <= 1'b0;
      full_q  <= 1'b0;
      run_q   <= 1'b0;
      for (int i = 0; i < LAP_DEPTH; i++) laps_q[i] <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= live_d;
      disp_q  <= disp_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      show_q  <= show_d;
      ovf_q   <= ovf_d;
      full_q  <= (count_d == CNT_W'(LAP_DEPTH));
      run_q   <= (state_d == RUN);
      if (cap_en) laps_q[count_q[IDX_W-1:0]] <= live_q;
    end
  end

  assign bus.min_out   = disp_q.min;
  assign bus.sec_out   = disp_q.sec;
  assign bus.show_lap  = show_q;
  assign bus.lap_idx   = idx_q;
  assign bus.lap_count = count_q;
  assign bus.lap_full  = full_q;
  assign bus.running   = run_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed bench: three stopwatch instances (default, LAP_DEPTH=2, MAX_MIN=1)
// share one stimulus stream; each scenario checks the instance it targets.
module tb_lap_stopwatch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1, tick = 1'b0, set_p = 1'b0, lap_p = 1'b0, recall_p = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lap_stopwatch_if #(.MAX_MIN(59), .LAP_DEPTH(8)) if_main ();
  lap_stopwatch_if #(.MAX_MIN(59), .LAP_DEPTH(2)) if_small ();
  lap_stopwatch_if #(.MAX_MIN(1),  .LAP_DEPTH(8)) if_ovf ();

  assign if_main.stopwatch_mode_en  = en;
  assign if_main.sec_tick           = tick;
  assign if_main.set                = set_p;
  assign if_main.lap                = lap_p;
  assign if_main.recall             = recall_p;
  assign if_small.stopwatch_mode_en = en;
  assign if_small.sec_tick          = tick;
  assign if_small.set               = set_p;
  assign if_small.lap               = lap_p;
  assign if_small.recall            = recall_p;
  assign if_ovf.stopwatch_mode_en   = en;
  assign if_ovf.sec_tick            = tick;
  assign if_ovf.set                 = set_p;
  assign if_ovf.lap                 = lap_p;
  assign if_ovf.recall              = recall_p;

  lap_stopwatch #(.MAX_MIN(59), .LAP_DEPTH(8), .HOLD_TICKS(2))
    u_main (.clk(clk), .rst(rst), .bus(if_main));
  lap_stopwatch #(.MAX_MIN(59), .LAP_DEPTH(2), .HOLD_TICKS(2))
    u_small (.clk(clk), .rst(rst), .bus(if_small));
  lap_stopwatch #(.MAX_MIN(1), .LAP_DEPTH(8), .HOLD_TICKS(2))
    u_ovf (.clk(clk), .rst(rst), .bus(if_ovf));

  // Packed views {min, sec, show_lap, lap_idx, lap_count, lap_full, running, overflow}
  wire [22:0] obs_main  = {if_main.min_out, if_main.sec_out, if_main.show_lap,
                           if_main.lap_idx, if_main.lap_count, if_main.lap_full,
                           if_main.running, if_main.overflow};
  wire [18:0] obs_small = {if_small.min_out, if_small.sec_out, if_small.show_lap,
                           if_small.lap_idx, if_small.lap_count, if_small.lap_full,
                           if_small.running, if_small.overflow};
  wire [17:0] obs_ovf   = {if_ovf.min_out, if_ovf.sec_out, if_ovf.show_lap,
                           if_ovf.lap_idx, if_ovf.lap_count, if_ovf.lap_full,
                           if_ovf.running, if_ovf.overflow};

  // Drives one cycle of pulses from a negedge; returns at the next negedge.
  task automatic step(input logic t, input logic s, input logic l, input logic r);
    tick = t; set_p = s; lap_p = l; recall_p = r;
    @(negedge clk);
    tick = 1'b0; set_p = 1'b0; lap_p = 1'b0; recall_p = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (obs_main !== 23'd0) begin
      errors++; $display("FAIL reset_main: got %h expected %h", obs_main, 23'd0);
    end
    checks++;
    if (obs_small !== 19'd0) begin
      errors++; $display("FAIL reset_small: got %h expected %h", obs_small, 19'd0);
    end
    checks++;
    if (obs_ovf !== 18'd0) begin
      errors++; $display("FAIL reset_ovf: got %h expected %h", obs_ovf, 18'd0);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_count;
    logic [22:0] exp;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    exp = {6'd0, 6'd0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs_main !== exp) begin
      errors++; $display("FAIL start_run: got %h expected %h", obs_main, exp);
    end
    ticks(75);
    exp = {6'd1, 6'd15, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs_main !== exp) begin
      errors++; $display("FAIL count_75: got %h expected %h", obs_main, exp);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    exp = {6'd1, 6'd15, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs_main !== exp) begin
      errors++; $display("FAIL stop: got %h expected %h", obs_main, exp);
    end
    ticks(3);
    checks++;
    if (obs_main !== exp) begin
      errors++; $display("FAIL stopped_ticks: got %h expected %h", obs_main, exp);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_main !== 23'd0) begin
      errors++; $display("FAIL clear_after_count: got %h expected %h", obs_main, 23'd0);
    end
  endtask

  task automatic test_lap_hold;
    logic [22:0] exp;
    step(1'b1, 1'b1, 1'b0, 1'b0);  // tick with set from IDLE must not count
    exp = {6'd0, 6'd0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs_main !== exp) begin
      errors++; $display("FAIL idle_set_tick: got %h expected %h", obs_main, exp);
    end
    ticks(9);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    exp = {6'd0, 6'd9, 1'b1, 3'd0, 4'd1, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs_main !== exp) begin
      errors++; $display("FAIL lap_with_tick: got %h expected %h", obs_main, exp);
    end
    ticks(1);
    checks++;
    if (obs_main !== exp) begin
      errors++; $display("FAIL hold_1: got %h expected %h", obs_main, exp);
    end
    ticks(1);
    exp = {6'd0, 6'd12, 1'b0, 3'd0, 4'd1, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs_main !== exp) begin
      errors++; $display("FAIL hold_expire: got %h expected %h", obs_main, exp);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);  // lap1 = 0:12
    ticks(1);
    step(1'b0, 1'b0, 1'b1, 1'b0);  // lap2 = 0:13, restarts the hold
    ticks(1);
    exp = {6'd0, 6'd13, 1'b1, 3'd2, 4'd3, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs_main !== exp) begin
      errors++; $display("FAIL hold_restart: got %h expected %h", obs_main, exp);
    end
    ticks(1);
    exp = {6'd0, 6'd15, 1'b0, 3'd2, 4'd3, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs_main !== exp) begin
      errors++; $display("FAIL hold_restart_expire: got %h expected %h", obs_main, exp);
    end
  endtask

  task automatic test_recall;
    logic [22:0] exp;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    exp = {6'd0, 6'd9, 1'b1, 3'd0, 4'd3, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs_main !== exp) begin
      errors++; $display("FAIL recall_0: got %h expected %h", obs_main, exp);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    exp = {6'd0, 6'd12, 1'b1, 3'd1, 4'd3, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs_main !== exp) begin
      errors++; $display("FAIL recall_1: got %h expected %h", obs_main, exp);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    exp = {6'd0, 6'd15, 1'b0, 3'd2, 4'd3, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs_main !== exp) begin
      errors++; $display("FAIL recall_live: got %h expected %h", obs_main, exp);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    exp = {6'd0, 6'd9, 1'b1, 3'd0, 4'd3, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs_main !== exp) begin
      errors++; $display("FAIL recall_wrap: got %h expected %h", obs_main, exp);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0);  // set+lap in STOP: resume only
    exp = {6'd0, 6'd15, 1'b0, 3'd0, 4'd3, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs_main !== exp) begin
      errors++; $display("FAIL stop_set_lap: got %h expected %h", obs_main, exp);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0);  // set+lap in RUN: stop only
    exp = {6'd0, 6'd15, 1'b0, 3'd0, 4'd3, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs_main !== exp) begin
      errors++; $display("FAIL run_set_lap: got %h expected %h", obs_main, exp);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_main !== 23'd0) begin
      errors++; $display("FAIL clear_after_recall: got %h expected %h", obs_main, 23'd0);
    end
  endtask

  task automatic test_lap_full;
    logic [18:0] exp;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1);
    step(1'b0, 1'b0, 1'b1, 1'b0);  // lap0 = 0:01
    ticks(1);
    step(1'b0, 1'b0, 1'b1, 1'b0);  // lap1 = 0:02, buffer full
    ticks(1);
    step(1'b0, 1'b0, 1'b1, 1'b0);  // dropped
    exp = {6'd0, 6'd2, 1'b1, 1'd1, 2'd2, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs_small !== exp) begin
      errors++; $display("FAIL full_drop: got %h expected %h", obs_small, exp);
    end
    ticks(1);
    step(1'b0, 1'b0, 1'b1, 1'b0);  // dropped with no hold active
    exp = {6'd0, 6'd4, 1'b0, 1'd1, 2'd2, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs_small !== exp) begin
      errors++; $display("FAIL full_no_freeze: got %h expected %h", obs_small, exp);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    exp = {6'd0, 6'd1, 1'b1, 1'd0, 2'd2, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs_small !== exp) begin
      errors++; $display("FAIL full_recall_0: got %h expected %h", obs_small, exp);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    exp = {6'd0, 6'd2, 1'b1, 1'd1, 2'd2, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs_small !== exp) begin
      errors++; $display("FAIL full_recall_1: got %h expected %h", obs_small, exp);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    exp = {6'd0, 6'd4, 1'b0, 1'd1, 2'd2, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs_small !== exp) begin
      errors++; $display("FAIL full_recall_live: got %h expected %h", obs_small, exp);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_overflow;
    logic [17:0] exp;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(119);
    exp = {1'd1, 6'd59, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs_ovf !== exp) begin
      errors++; $display("FAIL pre_wrap: got %h expected %h", obs_ovf, exp);
    end
    ticks(1);
    exp = {1'd0, 6'd0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b1};
    checks++;
    if (obs_ovf !== exp) begin
      errors++; $display("FAIL wrap: got %h expected %h", obs_ovf, exp);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_ovf !== 18'd0) begin
      errors++; $display("FAIL ovf_clear: got %h expected %h", obs_ovf, 18'd0);
    end
  endtask

  task automatic test_mode_en;
    logic [22:0] exp;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    exp = {6'd0, 6'd2, 1'b1, 3'd1, 4'd2, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs_main !== exp) begin
      errors++; $display("FAIL two_laps: got %h expected %h", obs_main, exp);
    end
    en = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_main !== 23'd0) begin
      errors++; $display("FAIL mode_off_clear: got %h expected %h", obs_main, 23'd0);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);  // ignored while disabled
    checks++;
    if (obs_main !== 23'd0) begin
      errors++; $display("FAIL mode_off_ignore: got %h expected %h", obs_main, 23'd0);
    end
    en = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1);
    exp = {6'd0, 6'd1, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs_main !== exp) begin
      errors++; $display("FAIL mode_on_run: got %h expected %h", obs_main, exp);
    end
  endtask

  task automatic test_async_reset;
    logic [22:0] exp;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    exp = {6'd0, 6'd1, 1'b1, 3'd0, 4'd1, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs_main !== exp) begin
      errors++; $display("FAIL pre_reset_hold: got %h expected %h", obs_main, exp);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs_main !== 23'd0) begin
      errors++; $display("FAIL async_reset: got %h expected %h", obs_main, 23'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b1, 1'b1);  // IDLE ignores tick, lap, recall
    checks++;
    if (obs_main !== 23'd0) begin
      errors++; $display("FAIL post_reset_idle: got %h expected %h", obs_main, 23'd0);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    exp = {6'd0, 6'd0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs_main !== exp) begin
      errors++; $display("FAIL post_reset_run: got %h expected %h", obs_main, exp);
    end
  endtask

  initial begin
    test_reset;
    test_count;
    test_lap_hold;
    test_recall;
    test_lap_full;
    test_overflow;
    test_mode_en;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
